// File: rtl/uart_rec.sv
// UART receive end: realigns a bit-period timer to the transmitter's sendSig
// rising edge, samples bsIn at mid-bit (LSB first) and emits a parallel word.
module uart_rec #(
  parameter int packetSize      = 4,
  parameter int cycleDiv        = 100,
  parameter int propDelayOffset = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bsIn,
  input  logic                  sendSig,
  output logic [packetSize-1:0] data,
  output logic                  dataValid,
  output logic                  busy
);

  localparam int CW = $clog2(cycleDiv);
  localparam int BW = $clog2(packetSize + 1);
  localparam int DW = (propDelayOffset > 0) ? $clog2(propDelayOffset + 1) : 1;

  localparam logic [CW-1:0] CNT_MID  = CW'(cycleDiv / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(cycleDiv - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(packetSize - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'((propDelayOffset > 0) ? propDelayOffset - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DW-1:0]         dly_q, dly_d;
  logic [packetSize-1:0] shift_q, shift_d;
  logic [packetSize-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ss_q;

  logic                  mid_bit;
  logic [packetSize:0]   shift_in;

  assign mid_bit  = (cnt_q == CNT_MID);
  assign shift_in = {bsIn, shift_q};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    dly_d   = dly_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sendSig && !ss_q) begin
          // The edge cycle itself is phase 0, so the next cycle is phase 1.
          state_d = S_START;
          cnt_d   = CW'(1);
          bit_d   = '0;
          dly_d   = '0;
        end
      end
      S_START: begin
        if (mid_bit) begin
          if (!sendSig)                  state_d = S_IDLE;
          else if (propDelayOffset == 0) state_d = S_DATA;
          else                           state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (mid_bit) begin
          dly_d = dly_q + DW'(1);
          if (dly_q == DLY_LAST) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          shift_d = shift_in[packetSize:1];
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            // Load the word on entry so data and dataValid are both seen in DONE.
            state_d = S_DONE;
            data_d  = shift_in[packetSize:1];
            valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      dly_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      dly_q   <= dly_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ss_q    <= sendSig;
    end
  end

  assign data      = data_q;
  assign dataValid = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rec.sv
// Bench for uart_rec: two instances (offset 0 and 2) share random stimulus and
// are checked every cycle against a frame-timing model plus literal pins.
module tb_uart_rec;

  localparam int N    = 4;
  localparam int D    = 10;
  localparam int HALF = D / 2;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bs_in;
  logic       send_sig;
  logic [3:0] data0, data1;
  logic       valid0, valid1, busy0, busy1;

  always #5 clk = ~clk;

  uart_rec #(.packetSize(N), .cycleDiv(D), .propDelayOffset(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bsIn(bs_in), .sendSig(send_sig),
    .data(data0), .dataValid(valid0), .busy(busy0)
  );

  uart_rec #(.packetSize(N), .cycleDiv(D), .propDelayOffset(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bsIn(bs_in), .sendSig(send_sig),
    .data(data1), .dataValid(valid1), .busy(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a frame is an alert time t0 plus a list of sample instants derived
  // from t0, the offset and the bit period; outputs follow from that timeline.
  int         p_of [2] = '{0, 2};
  bit         act_m [2];
  int         t0_m  [2];
  logic [3:0] acc_m [2];
  logic [3:0] dexp_m[2] = '{4'h0, 4'h0};
  bit         prev_ss = 1'b1;

  logic [3:0] dh  [2][HMAX];
  logic       vh  [2][HMAX];
  logic       bh  [2][HMAX];
  logic [3:0] edh [2][HMAX];
  logic       evh [2][HMAX];
  logic       ebh [2][HMAX];

  always @(negedge clk) begin : compare
    logic [3:0] d_o;
    logic       v_o, b_o;
    bit         ev, eb;
    int         j, k, done_j;
    for (int i = 0; i < 2; i++) begin
      d_o = (i == 0) ? data0  : data1;
      v_o = (i == 0) ? valid0 : valid1;
      b_o = (i == 0) ? busy0  : busy1;
      j = 0;
      done_j = (N + p_of[i]) * D + HALF + 1;
      if (!rst_n) begin
        act_m[i]  = 1'b0;
        dexp_m[i] = 4'h0;
        ev = 1'b0;
        eb = 1'b0;
      end else begin
        j  = cyc - t0_m[i];
        eb = act_m[i];
        ev = act_m[i] && (j == done_j);
        if (ev) dexp_m[i] = acc_m[i];
      end
      check($sformatf("dut%0d_data", i),  32'(d_o), 32'(dexp_m[i]));
      check($sformatf("dut%0d_valid", i), 32'(v_o), 32'(ev));
      check($sformatf("dut%0d_busy", i),  32'(b_o), 32'(eb));

      if (rst_n) begin
        if (act_m[i]) begin
          if (j == HALF && !send_sig) act_m[i] = 1'b0;
          else if (j == done_j)       act_m[i] = 1'b0;
          else if (j >= (1 + p_of[i]) * D + HALF && (j - HALF) % D == 0) begin
            k = (j - HALF) / D - 1 - p_of[i];
            if (k < N) acc_m[i][k] = bs_in;
          end
        end else if (send_sig && !prev_ss) begin
          act_m[i] = 1'b1;
          t0_m[i]  = cyc;
          acc_m[i] = 4'h0;
        end
      end

      if (cyc < HMAX) begin
        dh[i][cyc]  = d_o;
        vh[i][cyc]  = v_o;
        bh[i][cyc]  = b_o;
        edh[i][cyc] = dexp_m[i];
        evh[i][cyc] = ev;
        ebh[i][cyc] = eb;
      end
    end
    prev_ss = rst_n ? send_sig : 1'b1;
  end

  // Drives one alert/bit sequence starting in the current cycle (c = 0 is T0).
  task automatic run_frame(input int bit_off, input logic [3:0] bits, input int ss_len,
                           input int total, input int retrig);
    for (int c = 0; c < total; c++) begin
      send_sig = (c < ss_len) || (c == retrig);
      if (c >= bit_off && c < bit_off + N * D) bs_in = bits[(c - bit_off) / D];
      else bs_in = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      send_sig = 1'b0;
      bs_in    = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  function automatic int count_valid(input int dut, input int from, input int upto);
    int n = 0;
    for (int c = from; c <= upto; c++) if (vh[dut][c]) n++;
    return n;
  endfunction

  initial begin
    int         t0, t1;
    int         nb;
    logic [3:0] r;
    rst_n = 1'b0; send_sig = 1'b0; bs_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data",  32'(data0),  32'h0);
    check("reset_valid", 32'(valid0), 32'h0);
    check("reset_busy",  32'(busy1),  32'h0);
    rst_n = 1'b1;
    idle(5);

    // Nominal frame 1,1,0,1.
    t0 = cyc;
    run_frame(10, 4'b1011, 10, 47, -1);
    check("s1_busy_t0",     32'(bh[0][t0]),      32'h0);
    check("s1_busy_t0p1",   32'(bh[0][t0+1]),    32'h1);
    check("s1_valid_t0p45", 32'(vh[0][t0+45]),   32'h0);
    check("s1_valid_t0p46", 32'(vh[0][t0+46]),   32'h1);
    check("s1_data_t0p46",  32'(dh[0][t0+46]),   32'hB);
    check("s1_busy_t0p46",  32'(bh[0][t0+46]),   32'h1);
    check("s1_model_valid", 32'(evh[0][t0+46]),  32'h1);

    // Hold: long idle with random bsIn.
    t1 = cyc;
    idle(200);
    check("s1_busy_t0p47",  32'(bh[0][t0+47]),   32'h0);
    check("s6_no_valid",    32'(count_valid(0, t1, t1 + 198)), 32'h0);
    check("s6_data_hold",   32'(dh[0][t1+198]),  32'hB);

    // Offset-2 instance: bits from T0+30.
    t0 = cyc;
    run_frame(30, 4'b1011, 10, 70, -1);
    idle(3);
    check("s2_valid_t0p65", 32'(vh[1][t0+65]),   32'h0);
    check("s2_valid_t0p66", 32'(vh[1][t0+66]),   32'h1);
    check("s2_data_t0p66",  32'(dh[1][t0+66]),   32'hB);
    check("s2_model_valid", 32'(evh[1][t0+66]),  32'h1);

    // Glitch: sendSig high for three cycles only.
    t0 = cyc;
    run_frame(10, 4'($urandom), 3, 30, -1);
    check("s3_busy_t0p5",   32'(bh[0][t0+5]),    32'h1);
    check("s3_busy_t0p6",   32'(bh[0][t0+6]),    32'h0);
    check("s3_model_busy",  32'(ebh[1][t0+6]),   32'h0);
    check("s3_no_valid",    32'(count_valid(0, t0, t0 + 28) + count_valid(1, t0, t0 + 28)), 32'h0);
    check("s3_data_hold",   32'(dh[0][t0+28]),   32'(edh[0][t0-1]));

    // Retrigger during DATA, then a back-to-back frame 0,1,0,0.
    t0 = cyc;
    run_frame(10, 4'b1011, 10, 47, 20);
    run_frame(10, 4'b0010, 10, 50, -1);
    idle(3);
    check("s4_data_first",  32'(dh[0][t0+46]),   32'hB);
    check("s4_valid_second", 32'(vh[0][t0+93]),  32'h1);
    check("s4_data_second", 32'(dh[0][t0+93]),   32'h2);
    check("s4_valid_count", 32'(count_valid(0, t0, t0 + 95)), 32'h2);

    // Reset mid-frame with sendSig held high through release.
    run_frame(10, 4'b1011, 10, 20, -1);
    rst_n = 1'b0; send_sig = 1'b1;
    #1;
    check("s5_rst_data",  32'(data0),  32'h0);
    check("s5_rst_valid", 32'(valid0), 32'h0);
    check("s5_rst_busy",  32'({busy1, busy0}), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    t1 = cyc;
    repeat (15) begin send_sig = 1'b1; bs_in = 1'($urandom); @(posedge clk); #1; end
    nb = 0;
    for (int c = t1; c < t1 + 15; c++) if (bh[0][c] || bh[1][c]) nb++;
    check("s5_no_start_high", 32'(nb), 32'h0);
    idle(2);
    r  = 4'($urandom);
    t0 = cyc;
    run_frame(10, r, 10, 50, -1);
    idle(3);
    check("s5_valid_after", 32'(vh[0][t0+46]), 32'h1);
    check("s5_data_after",  32'(dh[0][t0+46]), 32'(r));

    // Random frames: glitches, retriggers, both offsets, overlapping alerts.
    repeat (25) begin
      run_frame(($urandom_range(0, 1) == 0) ? 10 : 30, 4'($urandom), $urandom_range(1, 14),
                $urandom_range(15, 90), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 80) : -1);
      idle($urandom_range(0, 5));
    end
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
